// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
// Module   : serial_adder
// Purpose  : Bit-serial adder. A single full-adder slice and a carry register
//            consume one operand bit per clock, LSB first, giving a+b+cin.
// Revision : 1.0  initial release
// ============================================================================
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy,
    output logic             done
);

    localparam int c_CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_s;
    logic               r_c;
    logic [c_CNT_W-1:0] r_cnt;

    logic w_s;
    logic w_c;
    logic w_last;

    // Full-adder slice on the current LSBs and the running carry.
    assign w_s    = r_a[0] ^ r_b[0] ^ r_c;
    assign w_c    = (r_a[0] & r_b[0]) | (r_a[0] & r_c) | (r_b[0] & r_c);
    assign w_last = (r_cnt == c_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_s     <= '0;
            r_c     <= 1'b0;
            r_cnt   <= '0;
            sum     <= '0;
            cout    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (r_state)
                // DONE accepts start exactly like IDLE, enabling back-to-back adds.
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_s     <= '0;
                        r_c     <= cin;
                        r_cnt   <= '0;
                        r_state <= S_SHIFT;
                        busy    <= 1'b1;
                        done    <= 1'b0;
                    end else begin
                        r_state <= S_IDLE;
                        busy    <= 1'b0;
                        done    <= 1'b0;
                    end
                end
                S_SHIFT: begin
                    r_a   <= r_a >> 1;
                    r_b   <= r_b >> 1;
                    r_s   <= {w_s, r_s[WIDTH-1:1]};
                    r_c   <= w_c;
                    r_cnt <= r_cnt + c_CNT_W'(1);
                    if (w_last) begin
                        sum     <= {w_s, r_s[WIDTH-1:1]};
                        cout    <= w_c;
                        r_state <= S_DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_adder
// Purpose  : Directed and random self-checking bench for serial_adder (WIDTH=8).
// Revision : 1.0  initial release
// ============================================================================
module tb_serial_adder;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] sum;
    logic       cout;
    logic       busy;
    logic       done;

    int n_vec;
    int n_err;

    serial_adder #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .sum   (sum),
        .cout  (cout),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle; outputs are observed 1 ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one addition from the current cycle and check busy in cycles 1..8
    // and done/sum/cout in cycle 9. Returns positioned in the done cycle.
    task automatic add_seq(input string tag, input logic [7:0] ia, input logic [7:0] ib,
                           input logic ic, input logic [7:0] es, input logic ec);
        start = 1'b1; a = ia; b = ib; cin = ic;
        step();
        start = 1'b0;
        a = ~ia; b = ia ^ ib; cin = ~ic;
        for (int i = 1; i <= 8; i++) begin
            chk({tag, " busy/done in shift"}, {30'd0, busy, done}, 32'b10);
            if (i < 8) step();
        end
        step();
        chk({tag, " busy/done at done"}, {30'd0, busy, done}, 32'b01);
        chk({tag, " sum"}, {24'd0, sum}, {24'd0, es});
        chk({tag, " cout"}, {31'd0, cout}, {31'd0, ec});
    endtask

    initial begin
        logic [7:0] ra, rb;
        logic       rc;
        logic [8:0] ref_res;
        n_vec = 0; n_err = 0;
        rst = 1'b1; start = 1'b0; a = 8'h00; b = 8'h00; cin = 1'b0;
        step(); step();
        chk("reset outputs", {21'd0, sum, cout, busy, done}, 32'd0);
        rst = 1'b0;
        step();
        chk("idle after reset", {30'd0, busy, done}, 32'd0);

        add_seq("0F+01", 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0);
        step();
        chk("done one cycle", {31'd0, done}, 32'd0);
        chk("sum held in idle", {24'd0, sum}, 32'h10);

        add_seq("FF+01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
        step();
        add_seq("FF+FF+1", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);
        step();
        add_seq("00+00+1", 8'h00, 8'h00, 1'b1, 8'h01, 1'b0);
        step();

        // Start while busy must be ignored.
        start = 1'b1; a = 8'h12; b = 8'h34; cin = 1'b0;
        step();
        start = 1'b0;
        step();
        chk("sum held during shift", {24'd0, sum}, 32'h01);
        start = 1'b1; a = 8'hFF; b = 8'hFF; cin = 1'b1;
        step();
        start = 1'b0;
        for (int i = 3; i <= 8; i++) begin
            chk("ignored start busy", {30'd0, busy, done}, 32'b10);
            step();
        end
        chk("ignored start done", {30'd0, busy, done}, 32'b01);
        chk("ignored start sum", {23'd0, cout, sum}, 32'h046);
        step();

        // Reset mid-shift aborts with no done pulse.
        start = 1'b1; a = 8'h80; b = 8'h80; cin = 1'b0;
        step();
        start = 1'b0;
        step(); step(); step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid reset outputs", {21'd0, sum, cout, busy, done}, 32'd0);
        begin
            int seen;
            seen = 0;
            for (int i = 0; i < 12; i++) begin
                step();
                if (done || busy) seen++;
            end
            chk("no done after abort", seen, 0);
        end
        add_seq("01+02 after reset", 8'h01, 8'h02, 1'b0, 8'h03, 1'b0);
        step();

        // Back-to-back: second start in the done cycle.
        add_seq("01+01", 8'h01, 8'h01, 1'b0, 8'h02, 1'b0);
        start = 1'b1; a = 8'h10; b = 8'h20; cin = 1'b0;
        step();
        start = 1'b0;
        chk("b2b busy next cycle", {30'd0, busy, done}, 32'b10);
        chk("b2b sum held", {24'd0, sum}, 32'h02);
        for (int i = 2; i <= 8; i++) step();
        chk("b2b still busy", {30'd0, busy, done}, 32'b10);
        step();
        chk("b2b done", {30'd0, busy, done}, 32'b01);
        chk("b2b sum", {23'd0, cout, sum}, 32'h030);
        step();

        // Random regression, often back-to-back from the done cycle.
        for (int k = 0; k < 1000; k++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rc = 1'($urandom);
            ref_res = {1'b0, ra} + {1'b0, rb} + {8'd0, rc};
            add_seq("random", ra, rb, rc, ref_res[7:0], ref_res[8]);
            if ($urandom_range(0, 1) == 0) step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
